// File: rtl/timer256_irq_ctrl_pkg.sv
// rtl/timer256_irq_ctrl_pkg.sv - shared constants, state type and priority helper for the 256 Hz timer interrupt controller
package timer256_irq_pkg;

    localparam int NUM_SRC = 4;

    localparam int SRC_32HZ = 0;
    localparam int SRC_8HZ  = 1;
    localparam int SRC_2HZ  = 2;
    localparam int SRC_1HZ  = 3;

    // Timer bit whose falling edge produces each source, indexed by source number.
    localparam int TIMER_BIT [NUM_SRC] = '{2, 4, 6, 7};

    localparam logic [23:0] ADDR_ENABLE_DEF  = 24'h2044;
    localparam logic [23:0] ADDR_PENDING_DEF = 24'h2045;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } irq_state_e;

    // Lowest set index wins; returns 0 when nothing is set.
    function automatic logic [1:0] prio_idx(input logic [NUM_SRC-1:0] req);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/timer256_irq_ctrl_if.sv
// rtl/timer256_irq_ctrl_if.sv - system bus register port and CPU interrupt handshake
interface timer256_irq_ctrl_if;

    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic        irq_req;
    logic [1:0]  irq_vector;
    logic        irq_ack;

    modport master (
        output bus_write,
        output bus_read,
        output bus_address_in,
        output bus_data_in,
        input  bus_data_out,
        input  irq_req,
        input  irq_vector,
        output irq_ack
    );

    modport slave (
        input  bus_write,
        input  bus_read,
        input  bus_address_in,
        input  bus_data_in,
        output bus_data_out,
        output irq_req,
        output irq_vector,
        input  irq_ack
    );

endinterface

// File: rtl/timer256_irq_ctrl_sync_fall_det.sv
// rtl/timer256_irq_ctrl_sync_fall_det.sv - single-bit synchroniser with falling-edge pulse and suppress
module sync_fall_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic din,
    input  logic suppress,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    // History always tracks the synchronised level, so a suppressed or
    // reset-time transition is absorbed rather than reported later.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        sync_q <= sync_d;
        hist_q <= hist_d;
    end

    assign fall = hist_q & ~sync_q[SYNC_STAGES-1] & ~suppress;

endmodule

// File: rtl/timer256_irq_ctrl.sv
// rtl/timer256_irq_ctrl.sv - 32/8/2/1 Hz tick interrupt controller with pending/enable registers and req/ack FSM
module timer256_irq_ctrl
    import timer256_irq_pkg::*;
#(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [23:0] ADDR_ENABLE  = ADDR_ENABLE_DEF,
    parameter logic [23:0] ADDR_PENDING = ADDR_PENDING_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           timer,
    input  logic                 timer_clear,
    timer256_irq_ctrl_if.slave   bus
);

    logic [SYNC_STAGES-1:0] clr_sync_q, clr_sync_d;
    logic                   clr_dly_q, clr_dly_d;
    logic                   suppress;
    logic [NUM_SRC-1:0]     fall_vec;

    logic [NUM_SRC-1:0]     enable_q, enable_d;
    logic [NUM_SRC-1:0]     pending_q, pending_d;
    logic [NUM_SRC-1:0]     ack_clr, w1c;
    logic                   wr_enable, wr_pending;

    irq_state_e             state_q;
    logic                   irq_req_q;
    logic [1:0]             irq_vector_q;

    logic                   unused_bus_bits;

    // Clear is held off one extra cycle after it falls to cover skew
    // between its synchroniser and the timer bit synchronisers.
    always_comb begin
        clr_sync_d = {clr_sync_q[SYNC_STAGES-2:0], timer_clear};
        clr_dly_d  = clr_sync_q[SYNC_STAGES-1];
        suppress   = clr_sync_q[SYNC_STAGES-1] | clr_dly_q;
    end

    always_ff @(posedge clk) begin
        clr_sync_q <= clr_sync_d;
        clr_dly_q  <= clr_dly_d;
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        sync_fall_det #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_det (
            .clk      (clk),
            .din      (timer[TIMER_BIT[i]]),
            .suppress (suppress),
            .fall     (fall_vec[i])
        );
    end

    // Ack clear, then W1C, then edge set: a same-cycle edge always survives.
    always_comb begin
        wr_enable  = bus.bus_write && (bus.bus_address_in == ADDR_ENABLE);
        wr_pending = bus.bus_write && (bus.bus_address_in == ADDR_PENDING);
        ack_clr    = '0;
        if ((state_q == REQ) && bus.irq_ack) begin
            ack_clr[irq_vector_q] = 1'b1;
        end
        w1c       = wr_pending ? bus.bus_data_in[NUM_SRC-1:0] : '0;
        pending_d = ((pending_q & ~ack_clr) & ~w1c) | fall_vec;
        enable_d  = wr_enable ? bus.bus_data_in[NUM_SRC-1:0] : enable_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q  <= '0;
            pending_q <= '0;
        end else begin
            enable_q  <= enable_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            irq_req_q    <= 1'b0;
            irq_vector_q <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((pending_q & enable_q) != '0) begin
                        irq_vector_q <= prio_idx(pending_q & enable_q);
                        irq_req_q    <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (bus.irq_ack) begin
                        irq_req_q <= 1'b0;
                        state_q   <= HOLD;
                    end else if (!(pending_d[irq_vector_q] && enable_d[irq_vector_q])) begin
                        irq_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                HOLD: begin
                    irq_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    irq_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.bus_data_out = 8'd0;
        if (bus.bus_address_in == ADDR_ENABLE) begin
            bus.bus_data_out = {4'd0, enable_q};
        end else if (bus.bus_address_in == ADDR_PENDING) begin
            bus.bus_data_out = {4'd0, pending_q};
        end
    end

    assign bus.irq_req    = irq_req_q;
    assign bus.irq_vector = irq_vector_q;

    // Read data is address-decoded only; the strobe and upper write bits carry no state.
    assign unused_bus_bits = ^{bus.bus_read, bus.bus_data_in[7:4]};

endmodule

// File: tb/tb_timer256_irq_ctrl.sv
// tb/tb_timer256_irq_ctrl.sv - scoreboard bench for timer256_irq_ctrl
module tb_timer256_irq_ctrl;
    import timer256_irq_pkg::*;

    localparam logic [23:0] A_EN = 24'h2044;
    localparam logic [23:0] A_PD = 24'h2045;

    typedef struct packed {
        logic       req;
        logic [1:0] vec;
    } probe_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] timer;
    logic       timer_clear;
    logic       probe;
    logic       final_chk;
    logic       done;
    logic       prev_req;

    logic [7:0] rd_q [$];
    probe_t     pr_q [$];
    logic [1:0] irq_q [$];

    logic [7:0] exp_rd;
    probe_t     exp_pr;
    logic [1:0] exp_v;

    int checks = 0;
    int errors = 0;

    timer256_irq_ctrl_if bus_if ();

    timer256_irq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .timer       (timer),
        .timer_clear (timer_clear),
        .bus         (bus_if.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.bus_read) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected addr=%h", bus_if.bus_address_in);
            end else begin
                exp_rd = rd_q.pop_front();
                if (bus_if.bus_data_out !== exp_rd) begin
                    errors++;
                    $display("FAIL rd addr=%h got=%h exp=%h t=%0t", bus_if.bus_address_in,
                             bus_if.bus_data_out, exp_rd, $time);
                end
            end
        end
        if (probe) begin
            checks++;
            if (pr_q.size() == 0) begin
                errors++;
                $display("FAIL probe_unexpected");
            end else begin
                exp_pr = pr_q.pop_front();
                if ((bus_if.irq_req !== exp_pr.req) ||
                    (exp_pr.req && (bus_if.irq_vector !== exp_pr.vec))) begin
                    errors++;
                    $display("FAIL probe req=%b vec=%0d exp_req=%b exp_vec=%0d t=%0t",
                             bus_if.irq_req, bus_if.irq_vector, exp_pr.req, exp_pr.vec, $time);
                end
            end
        end
        if (bus_if.irq_req && !prev_req) begin
            checks++;
            if (irq_q.size() == 0) begin
                errors++;
                $display("FAIL irq_unexpected vec=%0d t=%0t", bus_if.irq_vector, $time);
            end else begin
                exp_v = irq_q.pop_front();
                if (bus_if.irq_vector !== exp_v) begin
                    errors++;
                    $display("FAIL irq_vec got=%0d exp=%0d t=%0t", bus_if.irq_vector, exp_v, $time);
                end
            end
        end
        prev_req <= bus_if.irq_req;
        if (final_chk && !done) begin
            checks++;
            if ((rd_q.size() != 0) || (pr_q.size() != 0) || (irq_q.size() != 0)) begin
                errors++;
                $display("FAIL leftover rd=%0d probe=%0d irq=%0d", rd_q.size(), pr_q.size(), irq_q.size());
            end
            done <= 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus_if.bus_write = 1'b0;
        bus_if.bus_read  = 1'b0;
        bus_if.irq_ack   = 1'b0;
        probe            = 1'b0;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic rd(input logic [23:0] a, input logic [7:0] e);
        bus_if.bus_read       = 1'b1;
        bus_if.bus_address_in = a;
        rd_q.push_back(e);
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        bus_if.bus_write      = 1'b1;
        bus_if.bus_address_in = a;
        bus_if.bus_data_in    = d;
    endtask

    task automatic pr(input logic r, input logic [1:0] v);
        probe = 1'b1;
        pr_q.push_back({r, v});
    endtask

    task automatic ack();
        bus_if.irq_ack = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                 = 1'b1;
        timer                 = 8'h00;
        timer_clear           = 1'b0;
        probe                 = 1'b0;
        final_chk             = 1'b0;
        done                  = 1'b0;
        prev_req              = 1'b0;
        bus_if.bus_write      = 1'b0;
        bus_if.bus_read       = 1'b0;
        bus_if.bus_address_in = 24'h0;
        bus_if.bus_data_in    = 8'h0;
        bus_if.irq_ack        = 1'b0;
        steps(5);
        reset = 1'b0;
        pr(1'b0, 2'd0); rd(A_EN, 8'h00); step();
        rd(A_PD, 8'h00); step();

        // src0 on 7->8, latency and ack
        wr(A_EN, 8'h0F); step();
        for (int v = 1; v <= 7; v++) begin
            timer = 8'(v);
            step();
        end
        steps(3);
        irq_q.push_back(2'd0);
        timer = 8'h08;
        steps(2);
        rd(A_PD, 8'h00); step();
        rd(A_PD, 8'h01); pr(1'b0, 2'd0); step();
        pr(1'b1, 2'd0); ack(); step();
        rd(A_PD, 8'h00); pr(1'b0, 2'd0); step();
        pr(1'b0, 2'd0); step();

        // 255->0 with mask off, then enable 1100
        wr(A_EN, 8'h00); step();
        timer = 8'hFF; steps(4);
        rd(A_PD, 8'h00); step();
        timer = 8'h00; steps(3);
        rd(A_PD, 8'h0F); pr(1'b0, 2'd0); step();
        irq_q.push_back(2'd2);
        wr(A_EN, 8'h0C); step();
        pr(1'b0, 2'd0); rd(A_EN, 8'h0C); step();
        pr(1'b1, 2'd2); ack(); irq_q.push_back(2'd3); step();
        rd(A_PD, 8'h0B); pr(1'b0, 2'd0); step();
        pr(1'b0, 2'd0); step();
        pr(1'b1, 2'd3); ack(); step();
        pr(1'b0, 2'd0); rd(A_PD, 8'h03); step();
        wr(A_PD, 8'hFF); step();
        rd(A_PD, 8'h00); step();

        // timer_clear masks forced-to-zero transition
        timer = 8'hFF; steps(4);
        rd(A_PD, 8'h00); step();
        timer_clear = 1'b1; steps(4);
        timer = 8'h00; steps(4);
        timer_clear = 1'b0; steps(5);
        rd(A_PD, 8'h00); pr(1'b0, 2'd0); step();

        // abort from REQ via W1C
        timer = 8'h10; steps(4);
        wr(A_EN, 8'h0F); step();
        irq_q.push_back(2'd1);
        timer = 8'h20; steps(3);
        pr(1'b0, 2'd0); step();
        pr(1'b1, 2'd1); wr(A_PD, 8'h02); step();
        pr(1'b0, 2'd0); rd(A_PD, 8'h00); step();
        pr(1'b0, 2'd0); step();

        // ack coincides with a fresh src0 edge
        timer = 8'h24; steps(4);
        irq_q.push_back(2'd0);
        timer = 8'h20; step();
        timer = 8'h24; step();
        timer = 8'h20; step();
        pr(1'b0, 2'd0); step();
        pr(1'b1, 2'd0); ack(); irq_q.push_back(2'd0); step();
        pr(1'b0, 2'd0); rd(A_PD, 8'h01); step();
        pr(1'b0, 2'd0); step();
        pr(1'b1, 2'd0); step();

        // reset during REQ
        reset = 1'b1;
        pr(1'b1, 2'd0); step();
        pr(1'b0, 2'd0); rd(A_PD, 8'h00); step();
        reset = 1'b0;
        rd(A_EN, 8'h00); step();
        rd(A_PD, 8'h00); pr(1'b0, 2'd0); step();

        // read mux corners
        wr(A_EN, 8'hFF); step();
        rd(A_EN, 8'h0F); step();
        rd(24'h2046, 8'h00); step();
        rd(24'h0044, 8'h00); step();
        steps(4);

        final_chk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer256_irq_ctrl.md
# timer256_irq_ctrl

Interrupt controller for the 256 Hz real-time timer. It watches the free-running 8-bit timer count, derives the 32/8/2/1 Hz tick events, latches them as pending flags, and masks them with CPU-programmable enables. It presents one prioritised request at a time to the CPU interrupt logic through a req/ack handshake. It sits beside the timer on the system bus and owns registers 0x2044–0x2045.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth for the timer bits entering the clk domain (minimum 2).
- ADDR_ENABLE, 24'h2044: address of the enable-mask register.
- ADDR_PENDING, 24'h2045: address of the pending register.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- timer  in  8  timer count; changes in the rt_clk domain, asynchronous to clk.
- timer_clear  in  1  high while the timer is being forced to 0; suppresses event detection.
- bus_write  in  1  write strobe; a write takes effect at the clk edge where it is sampled high.
- bus_read  in  1  read strobe; does not change state.
- bus_address_in  in  24  bus address.
- bus_data_in  in  8  write data.
- bus_data_out  out  8  combinational read data: {4'd0, enable} at ADDR_ENABLE, {4'd0, pending} at ADDR_PENDING, 0 elsewhere.
- irq_req  out  1  interrupt request to the CPU.
- irq_vector  out  2  source index of the current request; valid while irq_req=1.
- irq_ack  in  1  CPU acknowledge; one-cycle pulse.

## Operation
- Each source is a falling edge of one timer bit:
  - src0: bit 2 (32 Hz)
  - src1: bit 4 (8 Hz)
  - src2: bit 6 (2 Hz)
  - src3: bit 7 (1 Hz, wrap 255→0)
- Each of the four bits is synchronised on its own; the multi-bit value is never sampled as a bus.
- Edge detection is disabled while synchronised timer_clear=1, and for 1 cycle after it falls. The delay register is reloaded so the forced-to-0 transition is not seen as an event.
- A detected edge sets pending[i], regardless of enable[i].
- Writing 1 to pending[i] clears it. Writing 0 has no effect. Bits [7:4] are ignored.
- Writing enable[3:0] replaces the whole mask.
- Priority is fixed: lowest index wins.
- State machine:
  - IDLE: if (pending & enable) != 0, latch irq_vector = highest-priority index and go to REQ.
  - REQ: hold irq_req=1 with irq_vector stable.
    - On irq_ack: clear pending[irq_vector] and go to HOLD.
    - If pending[irq_vector] & enable[irq_vector] becomes 0 (W1C or mask write): go to IDLE without ack.
  - HOLD: irq_req=0 for exactly one cycle, then go to IDLE.
- irq_ack outside REQ is ignored.

## Timing
- Reset values: enable=0, pending=0, state=IDLE, irq_req=0, irq_vector=0, edge history = current synchronised bits (no event out of reset).
- Timer bit fall to pending set: SYNC_STAGES+1 clk edges (3 by default).
- pending&enable nonzero in IDLE to irq_req=1: 1 cycle.
- irq_ack sampled in REQ: pending bit cleared and irq_req=0 on the next cycle. Next request is possible 2 cycles after the ack.
- Simultaneous events:
  - Edge set and W1C on the same bit in the same cycle: set wins.
  - Edge set and ack on the same bit in the same cycle: the bit stays pending, so it re-requests after HOLD.
  - Write and ack in the same cycle: both apply, ack clear first, then W1C, then set.
- Abort from REQ: irq_req falls the cycle after the disabling write.
- A higher-priority source arriving during REQ does not preempt. It is served after HOLD.
- Reset mid-REQ: irq_req=0 on the next cycle and all pending is lost.

## Structure
- Package timer256_irq_pkg:
  - source index constants SRC_32HZ..SRC_1HZ
  - timer bit map {2,4,6,7}
  - register addresses
  - state enum {IDLE, REQ, HOLD}
- Sub-module sync_fall_det, instantiated 4×: SYNC_STAGES-flop synchroniser, history register, suppress input, 1-cycle fall pulse output.
- The main module holds the registers, the priority encoder, the FSM and the read mux.

## Test plan
- Reset, enable=4'hF, timer counts 0→8 → one src0 event on 7→8 (bit 2 falls 1→0 at 8). pending=4'b0001 3 cycles later. irq_req=1 with irq_vector=0 one cycle after that. Ack clears pending and drops irq_req.
- Timer 255→0 with enable=0 → pending=4'b1111 (bits 2,4,6,7 all fall), irq_req stays 0. Then write enable=4'b1100 → irq_vector=2. Ack → irq_vector=3 after the HOLD cycle.
- timer_clear held while the timer jumps 0xFF→0x00 → pending stays 0.
- In REQ with vector 1, write pending=8'h02 → irq_req drops the next cycle and the FSM returns to IDLE.
- Ack in the same cycle as a fresh src0 edge → pending[0] remains 1, and irq_req re-asserts with vector 0 after HOLD.
- Reset asserted during REQ → irq_req=0, pending=0, enable=0 on the next cycle. Reads of 0x2044/0x2045 return 0.
